// File: rtl/npc_pkg.sv
// rtl/npc_pkg.sv - shared NPC core constants and IFU state encoding
package npc_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] RESET_PC   = 32'h8000_0000;
  localparam logic [XLEN-1:0] FAULT_INST = 32'h0000_0000;

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2
  } ifu_state_e;

endpackage

// File: rtl/ifu_fetch.sv
// rtl/ifu_fetch.sv - multi-cycle instruction fetch unit, one outstanding imem read
module ifu_fetch
  import npc_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [XLEN-1:0] imem_rsp_data,
  input  logic            imem_rsp_err,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_inst,
  output logic [XLEN-1:0] out_pc,
  output logic            out_fault,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc
);

  ifu_state_e      state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic            drop_q, drop_d;
  logic [XLEN-1:0] inst_q, inst_d;
  logic [XLEN-1:0] opc_q, opc_d;
  logic            fault_q, fault_d;
  logic            aligned;
  logic            req_fire;

  assign aligned        = (pc_q[1:0] == 2'b00);
  assign imem_req_valid = !rst && (state_q == S_REQ) && aligned;
  assign imem_req_addr  = pc_q;
  assign req_fire       = imem_req_valid && imem_req_ready;

  assign out_valid = !rst && (state_q == S_HOLD);
  assign out_inst  = inst_q;
  assign out_pc    = opc_q;
  assign out_fault = fault_q;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    drop_d  = drop_q;
    inst_d  = inst_q;
    opc_d   = opc_q;
    fault_d = fault_q;

    case (state_q)
      S_REQ: begin
        if (!aligned) begin
          state_d = S_HOLD;
          fault_d = 1'b1;
          inst_d  = FAULT_INST;
          opc_d   = pc_q;
        end else if (req_fire) begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (imem_rsp_valid) begin
          if (drop_q) begin
            drop_d  = 1'b0;
            state_d = S_REQ;
          end else begin
            state_d = S_HOLD;
            fault_d = imem_rsp_err;
            inst_d  = imem_rsp_err ? FAULT_INST : imem_rsp_data;
            opc_d   = pc_q;
          end
        end
      end
      S_HOLD: begin
        if (out_ready) begin
          pc_d    = pc_q + 32'd4;
          state_d = S_REQ;
        end
      end
      default: state_d = S_REQ;
    endcase

    // Redirect wins; an issued-but-unanswered read must still be drained.
    if (redirect_valid) begin
      pc_d    = redirect_pc;
      inst_d  = inst_q;
      opc_d   = opc_q;
      fault_d = fault_q;
      if ((state_q == S_WAIT && !imem_rsp_valid) || (state_q == S_REQ && req_fire)) begin
        drop_d  = 1'b1;
        state_d = S_WAIT;
      end else begin
        drop_d  = 1'b0;
        state_d = S_REQ;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_REQ;
      pc_q    <= RESET_PC;
      drop_q  <= 1'b0;
      inst_q  <= FAULT_INST;
      opc_q   <= '0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      drop_q  <= drop_d;
      inst_q  <= inst_d;
      opc_q   <= opc_d;
      fault_q <= fault_d;
    end
  end

endmodule

// File: tb/tb_ifu_fetch.sv
// tb/tb_ifu_fetch.sv - directed self-checking bench for ifu_fetch
module tb_ifu_fetch;

  logic        clk;
  logic        rst;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        imem_rsp_err;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_inst;
  logic [31:0] out_pc;
  logic        out_fault;
  logic        redirect_valid;
  logic [31:0] redirect_pc;

  int n_total = 0;
  int n_pass  = 0;

  ifu_fetch dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .imem_rsp_err   (imem_rsp_err),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_inst       (out_inst),
    .out_pc         (out_pc),
    .out_fault      (out_fault),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp)
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    else
      n_pass++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Full REQ -> WAIT -> HOLD -> accept sequence with a one-cycle memory.
  task automatic fetch(input logic [31:0] addr, input logic [31:0] data,
                       input logic err, input logic [31:0] exp_inst);
    check("req_valid", {31'd0, imem_req_valid}, 32'd1);
    check("req_addr", imem_req_addr, addr);
    check("idle_out_valid", {31'd0, out_valid}, 32'd0);
    tick();
    check("wait_req_valid", {31'd0, imem_req_valid}, 32'd0);
    check("wait_out_valid", {31'd0, out_valid}, 32'd0);
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = data;
    imem_rsp_err   = err;
    tick();
    imem_rsp_valid = 1'b0;
    imem_rsp_err   = 1'b0;
    check("hold_out_valid", {31'd0, out_valid}, 32'd1);
    check("hold_out_pc", out_pc, addr);
    check("hold_out_inst", out_inst, exp_inst);
    check("hold_out_fault", {31'd0, out_fault}, {31'd0, err});
    check("hold_req_valid", {31'd0, imem_req_valid}, 32'd0);
    tick();
  endtask

  initial begin
    rst            = 1'b1;
    imem_req_ready = 1'b1;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = 32'd0;
    imem_rsp_err   = 1'b0;
    out_ready      = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = 32'd0;

    tick();
    tick();
    check("rst_req_valid", {31'd0, imem_req_valid}, 32'd0);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_out_pc", out_pc, 32'd0);
    check("rst_out_inst", out_inst, 32'd0);
    check("rst_out_fault", {31'd0, out_fault}, 32'd0);
    check("rst_addr", imem_req_addr, 32'h8000_0000);
    rst = 1'b0;
    #1;

    // Streaming, one instruction every third cycle
    fetch(32'h8000_0000, 32'h0010_0093, 1'b0, 32'h0010_0093);
    fetch(32'h8000_0004, 32'h0020_0113, 1'b0, 32'h0020_0113);
    fetch(32'h8000_0008, 32'h0030_0193, 1'b0, 32'h0030_0193);

    // Decode stall: output stable, no new request
    check("stall_req_addr", imem_req_addr, 32'h8000_000c);
    tick();
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = 32'h1234_5678;
    out_ready      = 1'b0;
    tick();
    imem_rsp_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check("stall_out_valid", {31'd0, out_valid}, 32'd1);
      check("stall_out_pc", out_pc, 32'h8000_000c);
      check("stall_out_inst", out_inst, 32'h1234_5678);
      check("stall_req_valid", {31'd0, imem_req_valid}, 32'd0);
      tick();
    end
    out_ready = 1'b1;
    tick();

    // Access fault response, then sequential continuation
    fetch(32'h8000_0010, 32'hdead_beef, 1'b1, 32'h0000_0000);
    fetch(32'h8000_0014, 32'h0040_0213, 1'b0, 32'h0040_0213);

    // Redirect while waiting: stale response swallowed
    check("pre_redir_addr", imem_req_addr, 32'h8000_0018);
    tick();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h8000_0100;
    tick();
    redirect_valid = 1'b0;
    check("drop_req_valid", {31'd0, imem_req_valid}, 32'd0);
    check("drop_out_valid", {31'd0, out_valid}, 32'd0);
    tick();
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = 32'hbad0_bad0;
    tick();
    imem_rsp_valid = 1'b0;
    check("post_drop_out_valid", {31'd0, out_valid}, 32'd0);
    fetch(32'h8000_0100, 32'h0050_0293, 1'b0, 32'h0050_0293);

    // Misaligned redirect target: fault without any request
    imem_req_ready = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h8000_0202;
    tick();
    redirect_valid = 1'b0;
    imem_req_ready = 1'b1;
    check("mis_req_valid", {31'd0, imem_req_valid}, 32'd0);
    out_ready = 1'b0;
    tick();
    check("mis_out_valid", {31'd0, out_valid}, 32'd1);
    check("mis_out_fault", {31'd0, out_fault}, 32'd1);
    check("mis_out_inst", out_inst, 32'h0000_0000);
    check("mis_out_pc", out_pc, 32'h8000_0202);
    check("mis_hold_req_valid", {31'd0, imem_req_valid}, 32'd0);

    // Redirect coinciding with accept: redirect target beats pc+4
    out_ready      = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h8000_0300;
    tick();
    redirect_valid = 1'b0;
    check("redir_acc_addr", imem_req_addr, 32'h8000_0300);
    check("redir_acc_out_valid", {31'd0, out_valid}, 32'd0);

    // Reset in S_WAIT, then a stale response
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    check("rst2_req_valid", {31'd0, imem_req_valid}, 32'd1);
    check("rst2_addr", imem_req_addr, 32'h8000_0000);
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = 32'hffff_ffff;
    tick();
    imem_rsp_valid = 1'b0;
    imem_req_ready = 1'b1;
    check("stale_out_valid", {31'd0, out_valid}, 32'd0);
    fetch(32'h8000_0000, 32'h0060_0313, 1'b0, 32'h0060_0313);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
